// File: rtl/mem_stage_nb_pkg.sv
// mem_stage_nb_pkg
//   Shared types and constants for the non-blocking MEM stage.
//   - LS_* : bit positions inside the one-hot load/store type vector
//            {lb,lbu,lh,lhu,lw,lwl,lwr}, with lb as the MSB.
//   - ent_state_e : per-entry completion state (waiting for data_ok, or done).
//   - ms_entry_t  : one queue entry, which holds everything WB needs plus the
//                   fields the load aligner uses.
package mem_stage_nb_pkg;

    localparam int LS_TYPE_W = 7;
    localparam int LS_LB     = 6;
    localparam int LS_LBU    = 5;
    localparam int LS_LH     = 4;
    localparam int LS_LHU    = 3;
    localparam int LS_LW     = 2;
    localparam int LS_LWL    = 1;
    localparam int LS_LWR    = 0;

    typedef enum logic {
        ENT_DONE = 1'b0,
        ENT_WAIT = 1'b1
    } ent_state_e;

    typedef struct packed {
        logic                 valid;
        ent_state_e           state;
        logic                 kill;
        logic                 is_load;
        logic [LS_TYPE_W-1:0] ls_type;
        logic [1:0]           offset;
        logic [31:0]          rt_value;
        logic [31:0]          result;
        logic                 gr_we;
        logic [4:0]           dest;
        logic [31:0]          pc;
    } ms_entry_t;

endpackage

// File: rtl/mem_stage_nb_load_align.sv
// load_align
//   Purely combinational load data alignment. It works on little-endian
//   addressing and follows the MIPS32 LWL/LWR merge rules.
//   Ports:
//     ls_type_i  [6:0]  one-hot {lb,lbu,lh,lhu,lw,lwl,lwr}
//     offset_i   [1:0]  address bits [1:0]
//     rdata_i    [31:0] raw word returned by the data SRAM
//     rt_value_i [31:0] old rt contents, merged in by LWL/LWR
//     result_o   [31:0] aligned and extended load result
module load_align
    import mem_stage_nb_pkg::*;
(
    input  logic [LS_TYPE_W-1:0] ls_type_i,
    input  logic [1:0]           offset_i,
    input  logic [31:0]          rdata_i,
    input  logic [31:0]          rt_value_i,
    output logic [31:0]          result_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] lwl_val;
    logic [31:0] lwr_val;

    always_comb begin
        byte_sel = rdata_i[{offset_i, 3'b000} +: 8];
        half_sel = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];

        // LWL fills the register from its MSB downward with the low bytes of the word.
        unique case (offset_i)
            2'd0:    lwl_val = {rdata_i[7:0],  rt_value_i[23:0]};
            2'd1:    lwl_val = {rdata_i[15:0], rt_value_i[15:0]};
            2'd2:    lwl_val = {rdata_i[23:0], rt_value_i[7:0]};
            default: lwl_val = rdata_i;
        endcase

        // LWR fills the register from its LSB upward with the high bytes of the word.
        unique case (offset_i)
            2'd0:    lwr_val = rdata_i;
            2'd1:    lwr_val = {rt_value_i[31:24], rdata_i[31:8]};
            2'd2:    lwr_val = {rt_value_i[31:16], rdata_i[31:16]};
            default: lwr_val = {rt_value_i[31:8],  rdata_i[31:24]};
        endcase

        result_o = rdata_i;
        if (ls_type_i[LS_LB])       result_o = {{24{byte_sel[7]}}, byte_sel};
        else if (ls_type_i[LS_LBU]) result_o = {24'd0, byte_sel};
        else if (ls_type_i[LS_LH])  result_o = {{16{half_sel[15]}}, half_sel};
        else if (ls_type_i[LS_LHU]) result_o = {16'd0, half_sel};
        else if (ls_type_i[LS_LW])  result_o = rdata_i;
        else if (ls_type_i[LS_LWL]) result_o = lwl_val;
        else if (ls_type_i[LS_LWR]) result_o = lwr_val;
    end

endmodule

// File: rtl/mem_stage_nb.sv
// mem_stage_nb
//   Non-blocking MEM stage. An in-order queue of up to DEPTH ops sits between
//   EXE and WB, so several data-SRAM requests can be outstanding at once. Ops
//   retire to WB in program order. A load retires once its data_ok has come
//   back and the data has been aligned.
//   A flush kills every queued op, but requests that were already issued still
//   consume their data_ok.
//   Optional feature (macro MS_LQ_BYPASS_EN): a load waiting at the head can
//   send its data to WB in the same cycle that its data_ok arrives.
//   Ports:
//     es_*               op from EXE, accepted on es_to_ms_valid & ms_allowin
//     data_sram_*        in-order responses for the outstanding requests
//     ms_flush           kills queued ops and drops a same-cycle enqueue
//     ws_allowin         WB back-pressure
//     ms_to_ws_valid/ms_gr_we/ms_dest/ms_final_result/ms_pc  head op to WB
//     ms_outstanding     requests issued that have no data_ok yet
//     ms_resp_err        sticky flag, set when data_ok arrives with nothing outstanding
//   Handshakes: a transfer happens in a cycle where valid and allowin are both
//   high. Valid never depends combinationally on the matching allowin.
module mem_stage_nb
    import mem_stage_nb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 es_to_ms_valid,
    output logic                 ms_allowin,
    input  logic                 es_mem_req,
    input  logic                 es_res_from_mem,
    input  logic [LS_TYPE_W-1:0] es_ls_type,
    input  logic [1:0]           es_ls_offset,
    input  logic [31:0]          es_rt_value,
    input  logic [31:0]          es_alu_result,
    input  logic                 es_gr_we,
    input  logic [4:0]           es_dest,
    input  logic [31:0]          es_pc,
    input  logic                 data_sram_data_ok,
    input  logic [31:0]          data_sram_rdata,
    input  logic                 ms_flush,
    input  logic                 ws_allowin,
    output logic                 ms_to_ws_valid,
    output logic                 ms_gr_we,
    output logic [4:0]           ms_dest,
    output logic [31:0]          ms_final_result,
    output logic [31:0]          ms_pc,
    output logic [PTR_W:0]       ms_outstanding,
    output logic                 ms_resp_err
);

    ms_entry_t        ent_q [DEPTH];
    ms_entry_t        ent_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [PTR_W:0]   outst_q, outst_d;
    logic             resp_err_q, resp_err_d;

    logic [PTR_W-1:0] resp_idx;
    logic             resp_found;
    logic [PTR_W:0]   n_free;
    logic             free_stop;
    logic [PTR_W:0]   pop_n;
    logic [31:0]      align_result;
    logic             data_ok_hit;
    logic             bypass;
    logic             head_live_done;
    logic             retire;
    logic             enq;

    // The response pointer is the oldest entry that is still waiting. Responses
    // come back in request order, so the next data_ok always belongs to this entry.
    always_comb begin
        resp_found = 1'b0;
        resp_idx   = rd_ptr_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (!resp_found && ent_q[rd_ptr_q + PTR_W'(i)].valid &&
                ent_q[rd_ptr_q + PTR_W'(i)].state == ENT_WAIT) begin
                resp_found = 1'b1;
                resp_idx   = rd_ptr_q + PTR_W'(i);
            end
        end
    end

    // Killed entries always form a contiguous run that starts at the head,
    // because a flush kills everything that is queued. Free the leading
    // killed-and-done run all at once. A killed entry that is still waiting
    // stops the run.
    always_comb begin
        n_free    = '0;
        free_stop = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!free_stop && ent_q[rd_ptr_q + PTR_W'(i)].valid &&
                ent_q[rd_ptr_q + PTR_W'(i)].kill &&
                ent_q[rd_ptr_q + PTR_W'(i)].state == ENT_DONE) begin
                n_free = n_free + (PTR_W+1)'(1);
            end else begin
                free_stop = 1'b1;
            end
        end
    end

    load_align u_load_align (
        .ls_type_i  (ent_q[resp_idx].ls_type),
        .offset_i   (ent_q[resp_idx].offset),
        .rdata_i    (data_sram_rdata),
        .rt_value_i (ent_q[resp_idx].rt_value),
        .result_o   (align_result)
    );

    // While outstanding is nonzero there is a waiting entry, so resp_idx is
    // valid whenever data_ok_hit is high.
    assign data_ok_hit = data_sram_data_ok && (outst_q != '0);

`ifdef MS_LQ_BYPASS_EN
    assign bypass = ent_q[rd_ptr_q].valid && ent_q[rd_ptr_q].state == ENT_WAIT &&
                    !ent_q[rd_ptr_q].kill && data_ok_hit && (resp_idx == rd_ptr_q) &&
                    !ms_flush;
`else
    assign bypass = 1'b0;
`endif

    assign head_live_done  = ent_q[rd_ptr_q].valid && ent_q[rd_ptr_q].state == ENT_DONE &&
                             !ent_q[rd_ptr_q].kill;
    assign ms_to_ws_valid  = head_live_done || bypass;
    assign ms_gr_we        = ent_q[rd_ptr_q].gr_we;
    assign ms_dest         = ent_q[rd_ptr_q].dest;
    assign ms_pc           = ent_q[rd_ptr_q].pc;
    assign ms_final_result = (bypass && ent_q[rd_ptr_q].is_load) ? align_result
                                                                  : ent_q[rd_ptr_q].result;
    assign ms_outstanding  = outst_q;
    assign ms_resp_err     = resp_err_q;
    assign ms_allowin      = (count_q < (PTR_W+1)'(DEPTH));

    assign retire = ms_to_ws_valid && ws_allowin;
    // The live head and a killed head are mutually exclusive, so a pop is
    // either one retire or the whole killed run.
    assign pop_n  = retire ? (PTR_W+1)'(1) : n_free;
    assign enq    = es_to_ms_valid && ms_allowin && !ms_flush;

    always_comb begin
        ent_d      = ent_q;
        resp_err_d = resp_err_q;

        // Complete the oldest waiting entry first, so that a flush in the same
        // cycle sees it as done and killed.
        if (data_ok_hit) begin
            ent_d[resp_idx].state = ENT_DONE;
            if (ent_q[resp_idx].is_load) begin
                ent_d[resp_idx].result = align_result;
            end
        end else if (data_sram_data_ok) begin
            resp_err_d = 1'b1;
        end

        for (int i = 0; i < DEPTH; i++) begin
            if ((PTR_W+1)'(i) < pop_n) begin
                ent_d[rd_ptr_q + PTR_W'(i)].valid = 1'b0;
            end
        end

        if (ms_flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (ent_d[i].valid) begin
                    ent_d[i].kill = 1'b1;
                end
            end
        end

        if (enq) begin
            ent_d[wr_ptr_q].valid    = 1'b1;
            ent_d[wr_ptr_q].state    = es_mem_req ? ENT_WAIT : ENT_DONE;
            ent_d[wr_ptr_q].kill     = 1'b0;
            ent_d[wr_ptr_q].is_load  = es_res_from_mem;
            ent_d[wr_ptr_q].ls_type  = es_ls_type;
            ent_d[wr_ptr_q].offset   = es_ls_offset;
            ent_d[wr_ptr_q].rt_value = es_rt_value;
            ent_d[wr_ptr_q].result   = es_alu_result;
            ent_d[wr_ptr_q].gr_we    = es_gr_we;
            ent_d[wr_ptr_q].dest     = es_dest;
            ent_d[wr_ptr_q].pc       = es_pc;
        end

        rd_ptr_d = rd_ptr_q + pop_n[PTR_W-1:0];
        wr_ptr_d = wr_ptr_q + PTR_W'(enq);
        count_d  = count_q + (PTR_W+1)'(enq) - pop_n;
        outst_d  = outst_q + (PTR_W+1)'(enq && es_mem_req) - (PTR_W+1)'(data_ok_hit);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            outst_q    <= '0;
            resp_err_q <= 1'b0;
        end else begin
            ent_q      <= ent_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            outst_q    <= outst_d;
            resp_err_q <= resp_err_d;
        end
    end

endmodule

// File: tb/tb_mem_stage_nb.sv
// tb_mem_stage_nb
//   Directed test of mem_stage_nb with a retire scoreboard. The expected WB
//   tuple {gr_we, dest, result} is queued when each live op is driven. A
//   monitor pops the queue on every WB handshake and compares.
//   Inputs are driven 1 time unit after the rising edge. Outputs are sampled
//   either at the falling edge or 1 time unit after the rising edge.
module tb_mem_stage_nb;

    localparam int W = 38;

    logic        clk;
    logic        reset;
    logic        es_to_ms_valid;
    logic        ms_allowin;
    logic        es_mem_req;
    logic        es_res_from_mem;
    logic [6:0]  es_ls_type;
    logic [1:0]  es_ls_offset;
    logic [31:0] es_rt_value;
    logic [31:0] es_alu_result;
    logic        es_gr_we;
    logic [4:0]  es_dest;
    logic [31:0] es_pc;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic        ms_flush;
    logic        ws_allowin;
    logic        ms_to_ws_valid;
    logic        ms_gr_we;
    logic [4:0]  ms_dest;
    logic [31:0] ms_final_result;
    logic [31:0] ms_pc;
    logic [2:0]  ms_outstanding;
    logic        ms_resp_err;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_item;
    int           total = 0;
    int           bad   = 0;
    logic [31:0]  pc_ctr = 32'hBFC0_0000;

    mem_stage_nb #(.DEPTH(4), .PTR_W(2)) dut (
        .clk               (clk),
        .reset             (reset),
        .es_to_ms_valid    (es_to_ms_valid),
        .ms_allowin        (ms_allowin),
        .es_mem_req        (es_mem_req),
        .es_res_from_mem   (es_res_from_mem),
        .es_ls_type        (es_ls_type),
        .es_ls_offset      (es_ls_offset),
        .es_rt_value       (es_rt_value),
        .es_alu_result     (es_alu_result),
        .es_gr_we          (es_gr_we),
        .es_dest           (es_dest),
        .es_pc             (es_pc),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .ms_flush          (ms_flush),
        .ws_allowin        (ws_allowin),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ms_gr_we          (ms_gr_we),
        .ms_dest           (ms_dest),
        .ms_final_result   (ms_final_result),
        .ms_pc             (ms_pc),
        .ms_outstanding    (ms_outstanding),
        .ms_resp_err       (ms_resp_err)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (!reset && ms_to_ws_valid && ws_allowin) begin
            total++;
            assert (exp_q.size() != 0)
            else begin
                bad++;
                $error("FAIL unexpected_retire observed pc=%0h dest=%0d expected no retire",
                       ms_pc, ms_dest);
            end
            if (exp_q.size() != 0) begin
                exp_item = exp_q.pop_front();
                total++;
                assert ({ms_gr_we, ms_dest, ms_final_result} === exp_item)
                else begin
                    bad++;
                    $error("FAIL retire_data observed=%0h expected=%0h",
                           {ms_gr_we, ms_dest, ms_final_result}, exp_item);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Present one op and hold it until accepted (bounded wait).
    task automatic send_op(input logic mem, input logic load, input logic [6:0] lst,
                           input logic [1:0] off, input logic [31:0] rt,
                           input logic [31:0] alu, input logic we, input logic [4:0] dst);
        int n;
        es_to_ms_valid  = 1'b1;
        es_mem_req      = mem;
        es_res_from_mem = load;
        es_ls_type      = lst;
        es_ls_offset    = off;
        es_rt_value     = rt;
        es_alu_result   = alu;
        es_gr_we        = we;
        es_dest         = dst;
        es_pc           = pc_ctr;
        pc_ctr          = pc_ctr + 32'd4;
        n = 0;
        @(negedge clk);
        while (!ms_allowin && n < 50) begin
            @(negedge clk);
            n++;
        end
        total++;
        assert (ms_allowin === 1'b1)
        else begin
            bad++;
            $error("FAIL send_timeout observed allowin=%b expected 1", ms_allowin);
        end
        @(posedge clk);
        #1;
        es_to_ms_valid = 1'b0;
    endtask

    task automatic data_ok(input logic [31:0] rd);
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = rd;
        tick(1);
        data_sram_data_ok = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            tick(1);
            n++;
        end
        total++;
        assert (exp_q.size() == 0)
        else begin
            bad++;
            $error("FAIL drain_timeout observed pending=%0d expected 0", exp_q.size());
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        reset             = 1'b1;
        es_to_ms_valid    = 1'b0;
        es_mem_req        = 1'b0;
        es_res_from_mem   = 1'b0;
        es_ls_type        = 7'd0;
        es_ls_offset      = 2'd0;
        es_rt_value       = 32'd0;
        es_alu_result     = 32'd0;
        es_gr_we          = 1'b0;
        es_dest           = 5'd0;
        es_pc             = 32'd0;
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'd0;
        ms_flush          = 1'b0;
        ws_allowin        = 1'b1;
        tick(3);
        reset = 1'b0;

        check("rst_valid", ms_to_ws_valid, 0);
        check("rst_allowin", ms_allowin, 1);
        check("rst_outstanding", ms_outstanding, 0);
        check("rst_resp_err", ms_resp_err, 0);

        // 1: non-mem op appears the cycle after enqueue
        exp_q.push_back({1'b1, 5'd5, 32'h0000_1234});
        send_op(1'b0, 1'b0, 7'd0, 2'd0, 32'd0, 32'h1234, 1'b1, 5'd5);
        check("t1_valid", ms_to_ws_valid, 1);
        check("t1_result", ms_final_result, 32'h1234);
        check("t1_dest", ms_dest, 5);
        wait_drain();

        // 2: fill with four lw, then responses in order
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back({1'b1, 5'(i + 1), 32'(10 + i)});
            send_op(1'b1, 1'b1, 7'b0000100, 2'd0, 32'd0, 32'd0, 1'b1, 5'(i + 1));
        end
        check("t2_allowin_full", ms_allowin, 0);
        check("t2_outstanding4", ms_outstanding, 4);
        tick(2);
        check("t2_full_no_valid", ms_to_ws_valid, 0);
        for (int i = 0; i < 4; i++) data_ok(32'(10 + i));
        wait_drain();
        check("t2_outstanding0", ms_outstanding, 0);

        // 3: alignment cases
        exp_q.push_back({1'b1, 5'd1, 32'hFFFF_FF80});
        send_op(1'b1, 1'b1, 7'b1000000, 2'd3, 32'd0, 32'd0, 1'b1, 5'd1);
        exp_q.push_back({1'b1, 5'd2, 32'h0000_0080});
        send_op(1'b1, 1'b1, 7'b0100000, 2'd3, 32'd0, 32'd0, 1'b1, 5'd2);
        exp_q.push_back({1'b1, 5'd3, 32'h1122_AABB});
        send_op(1'b1, 1'b1, 7'b0000001, 2'd2, 32'h1122_3344, 32'd0, 1'b1, 5'd3);
        exp_q.push_back({1'b1, 5'd4, 32'hCCDD_3344});
        send_op(1'b1, 1'b1, 7'b0000010, 2'd1, 32'h1122_3344, 32'd0, 1'b1, 5'd4);
        data_ok(32'h80FF_FFFF);
        data_ok(32'h80FF_FFFF);
        data_ok(32'hAABB_CCDD);
        data_ok(32'hAABB_CCDD);
        wait_drain();
        exp_q.push_back({1'b1, 5'd6, 32'hFFFF_8001});
        send_op(1'b1, 1'b1, 7'b0010000, 2'd2, 32'd0, 32'd0, 1'b1, 5'd6);
        exp_q.push_back({1'b1, 5'd7, 32'h0000_8001});
        send_op(1'b1, 1'b1, 7'b0001000, 2'd2, 32'd0, 32'd0, 1'b1, 5'd7);
        exp_q.push_back({1'b0, 5'd0, 32'h0000_0055});
        send_op(1'b1, 1'b0, 7'd0, 2'd0, 32'd0, 32'h55, 1'b0, 5'd0);
        data_ok(32'h8001_0000);
        data_ok(32'h8001_0000);
        data_ok(32'h0000_0000);
        wait_drain();

        // 4: flush with two loads in flight; a same-cycle enqueue is dropped
        send_op(1'b1, 1'b1, 7'b0000100, 2'd0, 32'd0, 32'd0, 1'b1, 5'd10);
        send_op(1'b1, 1'b1, 7'b0000100, 2'd0, 32'd0, 32'd0, 1'b1, 5'd11);
        ms_flush        = 1'b1;
        es_to_ms_valid  = 1'b1;
        es_mem_req      = 1'b0;
        es_res_from_mem = 1'b0;
        es_alu_result   = 32'h9999;
        es_dest         = 5'd9;
        tick(1);
        ms_flush       = 1'b0;
        es_to_ms_valid = 1'b0;
        check("t4_flush_valid", ms_to_ws_valid, 0);
        check("t4_flush_outstanding", ms_outstanding, 2);
        exp_q.push_back({1'b1, 5'd7, 32'h0000_0077});
        send_op(1'b1, 1'b1, 7'b0000100, 2'd0, 32'd0, 32'd0, 1'b1, 5'd7);
        check("t4_outstanding3", ms_outstanding, 3);
        data_ok(32'hDEAD_0001);
        check("t4_killed_no_valid", ms_to_ws_valid, 0);
        data_ok(32'hDEAD_0002);
        data_ok(32'h0000_0077);
        wait_drain();
        check("t4_outstanding0", ms_outstanding, 0);
        tick(2);
        check("t4_allowin", ms_allowin, 1);

        // 5: WB stall holds the head and lets a later response buffer
        ws_allowin = 1'b0;
        exp_q.push_back({1'b1, 5'd3, 32'h0000_0333});
        send_op(1'b0, 1'b0, 7'd0, 2'd0, 32'd0, 32'h333, 1'b1, 5'd3);
        exp_q.push_back({1'b1, 5'd4, 32'h0000_0444});
        send_op(1'b1, 1'b1, 7'b0000100, 2'd0, 32'd0, 32'd0, 1'b1, 5'd4);
        data_ok(32'h0000_0444);
        check("t5_outstanding0", ms_outstanding, 0);
        for (int i = 0; i < 5; i++) begin
            check("t5_hold_valid", ms_to_ws_valid, 1);
            check("t5_hold_result", ms_final_result, 32'h333);
            check("t5_hold_dest", ms_dest, 3);
            tick(1);
        end
        ws_allowin = 1'b1;
        wait_drain();

        // 6: stray response sets the sticky error
        data_ok(32'h5555_5555);
        check("t6_resp_err", ms_resp_err, 1);
        check("t6_no_valid", ms_to_ws_valid, 0);
        check("t6_outstanding", ms_outstanding, 0);
        tick(3);
        check("t6_resp_err_sticky", ms_resp_err, 1);

        // load-to-WB latency for a lw at the head
        exp_q.push_back({1'b1, 5'd8, 32'h0000_1BAD});
        send_op(1'b1, 1'b1, 7'b0000100, 2'd0, 32'd0, 32'd0, 1'b1, 5'd8);
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h0000_1BAD;
        #1;
`ifdef MS_LQ_BYPASS_EN
        check("t6_bypass_valid", ms_to_ws_valid, 1);
        check("t6_bypass_result", ms_final_result, 32'h1BAD);
        @(posedge clk);
        #1;
        data_sram_data_ok = 1'b0;
        check("t6_bypass_gone", ms_to_ws_valid, 0);
`else
        check("t6_same_cycle_no_valid", ms_to_ws_valid, 0);
        @(posedge clk);
        #1;
        data_sram_data_ok = 1'b0;
        check("t6_next_cycle_valid", ms_to_ws_valid, 1);
        check("t6_next_cycle_result", ms_final_result, 32'h1BAD);
`endif
        wait_drain();

        // reset mid-operation drops everything, including a same-cycle data_ok
        send_op(1'b1, 1'b1, 7'b0000100, 2'd0, 32'd0, 32'd0, 1'b1, 5'd12);
        send_op(1'b1, 1'b1, 7'b0000100, 2'd0, 32'd0, 32'd0, 1'b1, 5'd13);
        data_sram_data_ok = 1'b1;
        reset             = 1'b1;
        tick(1);
        reset             = 1'b0;
        data_sram_data_ok = 1'b0;
        check("rst2_outstanding", ms_outstanding, 0);
        check("rst2_allowin", ms_allowin, 1);
        check("rst2_resp_err", ms_resp_err, 0);
        check("rst2_valid", ms_to_ws_valid, 0);
        tick(3);
        check("rst2_still_idle", ms_to_ws_valid, 0);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
